// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and defaults for the data-memory arbiter
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;
  localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rr_picker: round-robin winner search starting just after the last winner
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);
  logic found;
  // first requester at or after (last+1) mod NREQ
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(last) + i) % NREQ]) begin
        found = 1'b1;
        idx   = IDW'((int'(last) + i) % NREQ);
      end
    end
    gnt[idx] = found;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin LSU arbiter with one outstanding transaction and response timeout
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   data_req_i,
  output logic [NREQ-1:0]   data_gnt_o,
  output logic [NREQ-1:0]   data_rvalid_o,
  input  logic [NREQ*32-1:0] data_addr_i,
  input  logic [NREQ-1:0]   data_we_i,
  input  logic [NREQ*4-1:0] data_be_i,
  input  logic [NREQ*32-1:0] data_wdata_i,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  output logic [31:0]       mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i,
  output logic              stray_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t          state;
  req_t            fields, sel;
  logic [IDW-1:0]  last, owner, pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic [CW-1:0]   cnt;
  logic            tmo, resp, in_wait;
  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req  (data_req_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );
  // request fields of the current round-robin winner
  always_comb begin
    sel.addr  = data_addr_i[int'(pick_idx)*32 +: 32];
    sel.we    = data_we_i[pick_idx];
    sel.be    = data_be_i[int'(pick_idx)*4 +: 4];
    sel.wdata = data_wdata_i[int'(pick_idx)*32 +: 32];
  end
  // grant and response are combinational; a reset cycle suppresses both
  always_comb begin
    in_wait       = state == WAIT && !rst_i;
    tmo           = cnt == CW'(TIMEOUT - 1);
    resp          = in_wait && (mem_rvalid_i || tmo);
    data_gnt_o    = (state == IDLE && !rst_i) ? pick_gnt : '0;
    data_rvalid_o = resp ? NREQ'(1) << owner : '0;
    data_rdata_o  = (in_wait && mem_rvalid_i) ? mem_rdata_i : '0;
    data_err_o    = resp && (mem_rvalid_i ? mem_err_i : 1'b1);
  end
  assign mem_addr_o  = fields.addr;
  assign mem_we_o    = fields.we;
  assign mem_be_o    = fields.be;
  assign mem_wdata_o = fields.wdata;
  // transaction FSM with registered memory request and sticky stray-response flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      owner     <= '0;
      fields    <= '0;
      cnt       <= '0;
      mem_req_o <= 1'b0;
      stray_o   <= 1'b0;
    end else begin
      if (mem_rvalid_i && state != WAIT) stray_o <= 1'b1;
      case (state)
        IDLE: if (|data_req_i) begin
          fields    <= sel;
          owner     <= pick_idx;
          last      <= pick_idx;
          mem_req_o <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: if (mem_gnt_i) begin
          mem_req_o <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: if (mem_rvalid_i || tmo) begin
          cnt   <= '0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for the data-memory arbiter
module tb_dmem_arbiter;
  localparam int N  = 2;
  localparam int TO = 4;
  typedef struct {int c; logic [31:0] rd; logic er;} exp_t;
  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [N-1:0]      data_req_i = '0;
  logic [N-1:0]      data_gnt_o, data_rvalid_o;
  logic [N*32-1:0]   data_addr_i = '0;
  logic [N-1:0]      data_we_i = '0;
  logic [N*4-1:0]    data_be_i = '0;
  logic [N*32-1:0]   data_wdata_i = '0;
  logic [31:0]       data_rdata_o;
  logic              data_err_o;
  logic              mem_req_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;
  logic [31:0]       mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i = '0;
  logic              mem_err_i = 1'b0;
  logic              stray_o;
  int                n_cmp = 0;
  int                n_err = 0;
  exp_t              q[$];

  dmem_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .stray_o(stray_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rvalid(input int budget);
    exp_t e;
    int   k = 0;
    #1;
    while (data_rvalid_o == '0 && k < budget) begin
      cyc();
      #1;
      k++;
    end
    if (data_rvalid_o == '0 || q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL rvalid_wait: observed rvalid %b queue %0d, expected response within %0d cycles",
             data_rvalid_o, q.size(), budget);
    end else begin
      e = q.pop_front();
      chk("rvalid_owner", 32'(data_rvalid_o), 32'(1) << e.c);
      chk("rdata", data_rdata_o, e.rd);
      chk("err", 32'(data_err_o), 32'(e.er));
    end
  endtask

  task automatic run_txn(input int c, input int gw, input int rw, input logic to,
                         input logic [31:0] rd, input logic er, input logic drop);
    logic [31:0] ea, ewd;
    logic [3:0]  ebe;
    logic        ewe;
    ea  = data_addr_i[c*32 +: 32];
    ewd = data_wdata_i[c*32 +: 32];
    ebe = data_be_i[c*4 +: 4];
    ewe = data_we_i[c];
    #1;
    chk("gnt", 32'(data_gnt_o), 32'(1) << c);
    chk("mem_req_grant_cycle", 32'(mem_req_o), 32'd0);
    cyc();
    if (drop) data_req_i[c] = 1'b0;
    repeat (gw) begin
      #1;
      chk("mem_req_held", 32'(mem_req_o), 32'd1);
      chk("mem_addr_held", mem_addr_o, ea);
      chk("mem_we_held", 32'(mem_we_o), 32'(ewe));
      chk("mem_be_held", 32'(mem_be_o), 32'(ebe));
      chk("mem_wdata_held", mem_wdata_o, ewd);
      chk("gnt_busy", 32'(data_gnt_o), 32'd0);
      cyc();
    end
    mem_gnt_i = 1'b1;
    #1;
    chk("mem_req", 32'(mem_req_o), 32'd1);
    chk("mem_addr", mem_addr_o, ea);
    chk("mem_we", 32'(mem_we_o), 32'(ewe));
    cyc();
    mem_gnt_i = 1'b0;
    if (to) begin
      repeat (TO - 1) begin
        #1;
        chk("no_early_rvalid", 32'(data_rvalid_o), 32'd0);
        chk("mem_req_low", 32'(mem_req_o), 32'd0);
        cyc();
      end
      q.push_back('{c, 32'd0, 1'b1});
      wait_rvalid(1);
    end else begin
      repeat (rw) begin
        #1;
        chk("no_early_rvalid", 32'(data_rvalid_o), 32'd0);
        chk("gnt_wait", 32'(data_gnt_o), 32'd0);
        cyc();
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rd;
      mem_err_i    = er;
      q.push_back('{c, rd, er});
      wait_rvalid(2);
    end
    cyc();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    rst_i = 1'b0;
    #1;
    chk("rst_gnt", 32'(data_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(data_rvalid_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_stray", 32'(stray_o), 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    // both cores request continuously: expect 0,1,0,1
    data_addr_i = {32'h0000_0020, 32'h0000_0010};
    data_be_i   = 8'hFF;
    data_req_i  = 2'b11;
    run_txn(0, 0, 0, 1'b0, 32'h0000_0011, 1'b0, 1'b0);
    run_txn(1, 0, 0, 1'b0, 32'h0000_0022, 1'b0, 1'b0);
    run_txn(0, 1, 0, 1'b0, 32'h0000_0033, 1'b1, 1'b0);
    run_txn(1, 0, 2, 1'b0, 32'h0000_0044, 1'b0, 1'b0);
    data_req_i = '0;
    // single core 0 read of 0x100, data two cycles after the memory grant
    data_addr_i[31:0] = 32'h0000_0100;
    data_we_i[0]      = 1'b0;
    data_be_i[3:0]    = 4'hF;
    data_req_i        = 2'b01;
    run_txn(0, 0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    chk("idle_rdata_zero", data_rdata_o, 32'd0);
    chk("idle_err_zero", 32'(data_err_o), 32'd0);
    // core 1 flag write with the memory grant withheld for 5 cycles
    data_addr_i[63:32]  = 32'h0000_0200;
    data_we_i[1]        = 1'b1;
    data_be_i[7:4]      = 4'hF;
    data_wdata_i[63:32] = 32'h0000_0001;
    data_req_i          = 2'b10;
    run_txn(1, 5, 0, 1'b0, 32'd0, 1'b0, 1'b1);
    data_we_i[1] = 1'b0;
    // response and timeout in the same cycle: normal response wins
    data_req_i = 2'b01;
    run_txn(0, 0, TO - 1, 1'b0, 32'hCAFE_0001, 1'b0, 1'b1);
    #1;
    chk("stray_after_race", 32'(stray_o), 32'd0);
    // timeout with no memory response, then a late response
    data_req_i = 2'b10;
    run_txn(1, 0, 0, 1'b1, 32'd0, 1'b0, 1'b1);
    cyc();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    #1;
    chk("late_rvalid_dropped", 32'(data_rvalid_o), 32'd0);
    chk("late_rdata_zero", data_rdata_o, 32'd0);
    chk("stray_not_yet", 32'(stray_o), 32'd0);
    cyc();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    #1;
    chk("stray_set", 32'(stray_o), 32'd1);
    cyc();
    #1;
    chk("stray_sticky", 32'(stray_o), 32'd1);
    // reset during WAIT aborts the transaction
    data_req_i = 2'b01;
    #1;
    chk("gnt_before_abort", 32'(data_gnt_o), 32'd1);
    cyc();
    data_req_i = '0;
    mem_gnt_i  = 1'b1;
    cyc();
    mem_gnt_i = 1'b0;
    rst_i     = 1'b1;
    #1;
    chk("abort_no_rvalid", 32'(data_rvalid_o), 32'd0);
    cyc();
    rst_i = 1'b0;
    #1;
    chk("abort_rvalid", 32'(data_rvalid_o), 32'd0);
    chk("abort_mem_req", 32'(mem_req_o), 32'd0);
    chk("abort_mem_addr", mem_addr_o, 32'd0);
    chk("abort_stray_cleared", 32'(stray_o), 32'd0);
    chk("abort_gnt", 32'(data_gnt_o), 32'd0);
    data_req_i = 2'b11;
    run_txn(0, 0, 0, 1'b0, 32'h0000_0055, 1'b0, 1'b1);
    data_req_i = '0;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
